// File: rtl/sseg_digit_arbiter.sv
// Digit register file for the 8-digit seven-segment display.
// Two requesters write single digits through valid/ready, arbitrated
// round-robin at one write per cycle. A clear pulse starts a sweep that
// blanks one digit per cycle. Digits flagged in blink_mask have their
// enable bit gated by a free-running blink phase.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | normal operation; requester writes are arbitrated and accepted
// CLEAR | sweep in progress; digit[idx] blanked each cycle, writes held off
module sseg_digit_arbiter #(
    parameter int BLINK_W = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_addr,
    input  logic [5:0] req0_data,
    input  logic       req0_blink,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_addr,
    input  logic [5:0] req1_data,
    input  logic       req1_blink,
    input  logic       clear,
    output logic       busy,
    output logic [5:0] d0,
    output logic [5:0] d1,
    output logic [5:0] d2,
    output logic [5:0] d3,
    output logic [5:0] d4,
    output logic [5:0] d5,
    output logic [5:0] d6,
    output logic [5:0] d7
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [5:0]           digit [8];
    logic [7:0]           blink_mask;
    logic                 rr_ptr;
    logic [2:0]           idx;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 grant0;
    logic                 grant1;
    logic                 phase;
    logic [5:0]           d_out [8];

    // State register; reset aborts any sweep in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and round-robin grants; clear outranks any request in IDLE.
    always_comb begin
        state_nx = state;
        grant0   = 1'b0;
        grant1   = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        state_nx = CLEAR;
                    end else if (req0_valid && req1_valid) begin
                        grant0 = ~rr_ptr;
                        grant1 = rr_ptr;
                    end else begin
                        grant0 = req0_valid;
                        grant1 = req1_valid;
                    end
                end
                CLEAR: begin
                    if (idx == 3'd7) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state == CLEAR);

    // Digit storage, blink mask, sweep index and priority pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                digit[i] <= 6'h00;
            end
            blink_mask <= 8'h00;
            rr_ptr     <= 1'b0;
            idx        <= 3'd0;
        end else if (state == CLEAR) begin
            digit[idx]      <= 6'h00;
            blink_mask[idx] <= 1'b0;
            idx             <= idx + 3'd1;
        end else if (clear) begin
            idx <= 3'd0;
        end else if (grant0) begin
            digit[req0_addr]      <= req0_data;
            blink_mask[req0_addr] <= req0_blink;
            rr_ptr                <= 1'b1;
        end else if (grant1) begin
            digit[req1_addr]      <= req1_data;
            blink_mask[req1_addr] <= req1_blink;
            rr_ptr                <= 1'b0;
        end
    end

    // Free-running blink counter; only reset clears it, the sweep does not.
    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + {{(BLINK_W-1){1'b0}}, 1'b1};
        end
    end

    assign phase = blink_cnt[BLINK_W-1];

    // Gate only the enable bit of blinking digits; value and dp pass through.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            d_out[i] = {digit[i][5] & ~(blink_mask[i] & phase), digit[i][4:0]};
        end
    end

    assign d0 = d_out[0];
    assign d1 = d_out[1];
    assign d2 = d_out[2];
    assign d3 = d_out[3];
    assign d4 = d_out[4];
    assign d5 = d_out[5];
    assign d6 = d_out[6];
    assign d7 = d_out[7];

endmodule

// File: tb/tb_sseg_digit_arbiter.sv
module tb_sseg_digit_arbiter;

    localparam int BLINK_W = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready, req0_blink;
    logic [2:0] req0_addr;
    logic [5:0] req0_data;
    logic       req1_valid, req1_ready, req1_blink;
    logic [2:0] req1_addr;
    logic [5:0] req1_data;
    logic       clear, busy;
    logic [5:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic [5:0] dv [8];

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [5:0] m_digit [8];
    logic       m_mask  [8];
    int         m_next;      // requester holding priority
    int         m_sweep;     // sweep cycles remaining, 0 when idle
    int         m_cycles;    // clock edges since last reset edge
    logic       chk_en;
    logic       last_g0, last_g1;

    always #5 clk = ~clk;

    sseg_digit_arbiter #(.BLINK_W(BLINK_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_blink(req0_blink),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_blink(req1_blink),
        .clear(clear), .busy(busy),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7)
    );

    assign dv[0] = d0; assign dv[1] = d1; assign dv[2] = d2; assign dv[3] = d3;
    assign dv[4] = d4; assign dv[5] = d5; assign dv[6] = d6; assign dv[7] = d7;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_digit(input int n);
        logic blink_off;
        // blink phase is high during the second half of every 16-cycle period
        blink_off = m_mask[n] && (((m_cycles % 16) / 8) == 1);
        return blink_off ? {1'b0, m_digit[n][4:0]} : m_digit[n];
    endfunction

    // Check outputs for the current inputs, clock once, advance the model.
    task automatic tick();
        logic e0, e1;
        e0 = 1'b0;
        e1 = 1'b0;
        #1;
        if (reset && m_sweep == 0 && !clear) begin
            if (req0_valid && req1_valid) begin
                e0 = (m_next == 0);
                e1 = (m_next == 1);
            end else begin
                e0 = req0_valid;
                e1 = req1_valid;
            end
        end
        if (chk_en) begin
            check("req0_ready", {7'd0, req0_ready}, {7'd0, e0});
            check("req1_ready", {7'd0, req1_ready}, {7'd0, e1});
            check("busy", {7'd0, busy}, {7'd0, (m_sweep != 0)});
            for (int i = 0; i < 8; i++) begin
                check($sformatf("d%0d", i), {2'b0, dv[i]}, {2'b0, exp_digit(i)});
            end
        end
        last_g0 = e0;
        last_g1 = e1;
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                m_digit[i] = 6'h00;
                m_mask[i]  = 1'b0;
            end
            m_next = 0; m_sweep = 0; m_cycles = 0;
        end else begin
            m_cycles++;
            if (m_sweep > 0) begin
                m_digit[8 - m_sweep] = 6'h00;
                m_mask[8 - m_sweep]  = 1'b0;
                m_sweep--;
            end else if (clear) begin
                m_sweep = 8;
            end else if (e0) begin
                m_digit[req0_addr] = req0_data;
                m_mask[req0_addr]  = req0_blink;
                m_next = 1;
            end else if (e1) begin
                m_digit[req1_addr] = req1_data;
                m_mask[req1_addr]  = req1_blink;
                m_next = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int busy_cnt;
        logic [5:0] base0, base1;
        chk_en = 1'b0;
        reset = 1'b0; clear = 1'b0;
        req0_valid = 1'b1; req0_addr = 3'd0; req0_data = 6'h00; req0_blink = 1'b0;
        req1_valid = 1'b0; req1_addr = 3'd0; req1_data = 6'h00; req1_blink = 1'b0;
        m_next = 0; m_sweep = 0; m_cycles = 0;
        for (int i = 0; i < 8; i++) begin m_digit[i] = 6'h00; m_mask[i] = 1'b0; end
        @(negedge clk);

        // reset held for two edges with a pending request
        tick();
        chk_en = 1'b1;
        tick();

        // single write from requester 0
        reset = 1'b1;
        req0_addr = 3'd3; req0_data = 6'b1_0101_1;
        tick();
        req0_valid = 1'b0;
        #1 check("d3_single", {2'b0, d3}, 8'h2B);
        tick();

        // contention: both requesters valid, data held until accepted
        base0 = 6'h20; base1 = 6'h30;
        req0_valid = 1'b1; req0_addr = 3'd0; req0_data = base0;
        req1_valid = 1'b1; req1_addr = 3'd1; req1_data = base1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (last_g0) begin base0 = base0 + 6'd1; req0_data = base0; end
            if (last_g1) begin base1 = base1 + 6'd1; req1_data = base1; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // preload every digit with 3F
        for (int a = 0; a < 8; a++) begin
            req0_valid = 1'b1; req0_addr = 3'(a); req0_data = 6'h3F; req0_blink = 1'b0;
            tick();
        end
        req0_valid = 1'b0;

        // clear sweep with a requester waiting and a second clear mid-sweep
        req1_valid = 1'b1; req1_addr = 3'd6; req1_data = 6'h25; req1_blink = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        busy_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            clear = (k == 4);
            #1 if (busy) busy_cnt++;
            tick();
        end
        clear = 1'b0;
        check("sweep_busy_len", 8'(busy_cnt), 8'd8);
        tick();
        req1_valid = 1'b0;
        #1 check("d6_after_sweep", {2'b0, d6}, 8'h25);
        tick();

        // blink on digit 5, steady digit 2
        req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 6'h3F; req0_blink = 1'b1;
        tick();
        req0_addr = 3'd2; req0_blink = 1'b0;
        tick();
        req0_valid = 1'b0;
        for (int k = 0; k < 20; k++) tick();

        // reset in the middle of a sweep
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1 check("busy_after_reset", {7'd0, busy}, 8'd0);
        req1_valid = 1'b1; req1_addr = 3'd4; req1_data = 6'h2A; req1_blink = 1'b1;
        tick();
        req1_valid = 1'b0;
        tick();

        // randomized traffic; pending requests held stable until accepted
        last_g0 = 1'b0; last_g1 = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!(req0_valid && !last_g0)) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_addr  = 3'($urandom_range(0, 7));
                req0_data  = 6'($urandom_range(0, 63));
                req0_blink = 1'($urandom_range(0, 1));
            end
            if (!(req1_valid && !last_g1)) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_addr  = 3'($urandom_range(0, 7));
                req1_data  = 6'($urandom_range(0, 63));
                req1_blink = 1'($urandom_range(0, 1));
            end
            clear = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 79) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
